// File: rtl/melody_player.sv
// melody_player: programmable square-wave melody sequencer.
//   Holds a writable song table of (frequency, duration) entries and plays
//   entries 0..last_idx in order, once or looped. Each tone's half-period is
//   computed at runtime by a 32-cycle restoring divider. The output is the
//   tone square wave gated by a free-running PWM carrier for volume.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_freq/wr_dur   song-table write port (any state)
//   start, stop              begin playback at entry 0 / abort playback
//   loop_en, last_idx        wrap after last entry / final entry (latched on start)
//   volume                   PWM level, 0 = mute
//   busy, note_idx, done     status: playing, current entry, completion pulse
//   pwm_out                  audio output
module melody_player #(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned FREQ_W      = 12,
    parameter int unsigned DUR_W       = 8,
    parameter int unsigned TICK_CYCLES = 2500000,
    parameter int unsigned VOL_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [FREQ_W-1:0] wr_freq,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic [VOL_W-1:0]  volume,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done,
    output logic              pwm_out
);

    localparam int unsigned DEPTH    = 2**ADDR_W;
    localparam logic [31:0] DIVIDEND = 32'(CLK_FREQ / 2);
    localparam logic [31:0] TICK_MAX = 32'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, PLAY, FIN} state_t;
    state_t state, state_nxt;

    // Song table: not reset, so contents survive a reset.
    logic [FREQ_W-1:0] freq_mem [DEPTH];
    logic [DUR_W-1:0]  dur_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            freq_mem[wr_addr] <= wr_freq;
            dur_mem[wr_addr]  <= wr_dur;
        end
    end

    logic [FREQ_W-1:0] cur_freq;
    logic [DUR_W-1:0]  cur_dur;
    logic [ADDR_W-1:0] last_q;
    logic [31:0]       rem, quo, half, hcnt, tick_cnt;
    logic [4:0]        div_cnt;
    logic [DUR_W-1:0]  tick_num;
    logic              phase;
    logic [VOL_W-1:0]  pc;

    // One restoring-division step: shift next dividend bit into the remainder.
    logic [32:0] shifted;
    logic [31:0] dvsr, rem_nxt, quo_nxt;
    logic        sub_ok;
    assign dvsr    = {{(32-FREQ_W){1'b0}}, cur_freq};
    assign shifted = {rem, quo[31]};
    assign sub_ok  = shifted >= {1'b0, dvsr};
    // When sub_ok the true difference fits 32 bits, so modulo subtract is exact.
    assign rem_nxt = sub_ok ? (shifted[31:0] - dvsr) : shifted[31:0];
    assign quo_nxt = {quo[30:0], sub_ok};

    logic [DUR_W-1:0] dur_eff;
    logic             play_end, advance, wrap;
    assign dur_eff  = (cur_dur == '0) ? DUR_W'(1) : cur_dur;
    assign play_end = (state == PLAY) && (tick_cnt == TICK_MAX)
                      && (tick_num == dur_eff - 1'b1);
    assign advance  = play_end && (note_idx != last_q);
    assign wrap     = play_end && (note_idx == last_q) && loop_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            // Decide rest vs. tone from the table word being latched this cycle.
            LOAD: state_nxt = (freq_mem[note_idx] == '0) ? PLAY : DIV;
            DIV:  if (div_cnt == 5'd31) state_nxt = PLAY;
            PLAY: if (play_end) state_nxt = (advance || wrap) ? LOAD : FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // stop wins over everything, including a same-cycle start in IDLE.
        if (stop) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_freq <= '0; cur_dur <= '0; last_q <= '0; note_idx <= '0;
            rem <= '0; quo <= '0; half <= '0; div_cnt <= '0;
            hcnt <= '0; phase <= 1'b0; tick_cnt <= '0; tick_num <= '0;
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
            case (state)
                IDLE: if (start && !stop) begin
                    last_q   <= last_idx;
                    note_idx <= '0;
                end
                LOAD: begin
                    cur_freq <= freq_mem[note_idx];
                    cur_dur  <= dur_mem[note_idx];
                    rem      <= '0;
                    quo      <= DIVIDEND;
                    div_cnt  <= '0;
                end
                DIV: begin
                    rem     <= rem_nxt;
                    quo     <= quo_nxt;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == 5'd31)
                        half <= (quo_nxt == 32'd0) ? 32'd1 : quo_nxt;
                end
                PLAY: if (!stop) begin
                    if (advance)   note_idx <= note_idx + 1'b1;
                    else if (wrap) note_idx <= '0;
                end
                default: ;
            endcase

            // Tone and tick counters run only in PLAY and restart from zero on
            // every entry, since LOAD always precedes PLAY.
            if (state == PLAY) begin
                if (hcnt == half - 32'd1) begin
                    hcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    hcnt <= hcnt + 32'd1;
                end
                if (tick_cnt == TICK_MAX) begin
                    tick_cnt <= '0;
                    tick_num <= tick_num + 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 32'd1;
                end
            end else begin
                hcnt     <= '0;
                phase    <= 1'b0;
                tick_cnt <= '0;
                tick_num <= '0;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign pwm_out = (state == PLAY) && (cur_freq != '0) && phase && (pc < volume);

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: directed self-checking bench for melody_player.
//   Small parameters (CLK_FREQ=1000, TICK_CYCLES=100) give dividend 500, so
//   freq 50 -> half 10, freq 100 -> half 5, freq 600 -> half 0 forced to 1.
//   Outputs are sampled on the falling edge; inputs change there too.
module tb_melody_player;

    localparam int ADDR_W = 5;
    localparam int FREQ_W = 12;
    localparam int DUR_W  = 8;
    localparam int VOL_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [FREQ_W-1:0] wr_freq;
    logic [DUR_W-1:0]  wr_dur;
    logic              start, stop, loop_en;
    logic [ADDR_W-1:0] last_idx;
    logic [VOL_W-1:0]  volume;
    logic              busy, done, pwm_out;
    logic [ADDR_W-1:0] note_idx;

    int checks   = 0;
    int failures = 0;
    int cyc;   // rising edges since reset release = expected PWM carrier count

    melody_player #(
        .CLK_FREQ(1000), .ADDR_W(ADDR_W), .FREQ_W(FREQ_W), .DUR_W(DUR_W),
        .TICK_CYCLES(100), .VOL_W(VOL_W)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_dur(wr_dur), .start(start), .stop(stop),
        .loop_en(loop_en), .last_idx(last_idx), .volume(volume),
        .busy(busy), .note_idx(note_idx), .done(done), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_entry(input int a, input int f, input int d);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_freq = FREQ_W'(f); wr_dur = DUR_W'(d);
        step();
        wr_en = 1'b0;
    endtask

    // Leaves the bench at the first sample after start was taken (LOAD).
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Checks one note: its gap (1 cycle for a rest, 33 for a tone) and then
    // len PLAY cycles against the square-wave/carrier model. half=0 means rest.
    // act 1 clears loop_en, act 2 rewrites entry0=(100,1), at PLAY cycle act_at.
    task automatic note(input int idx, input int half, input int len, input int vol,
                        input int act_at, input int act, input string nm);
        int   errs;
        int   gap;
        logic e;
        errs = 0;
        gap  = (half == 0) ? 1 : 33;
        for (int i = 0; i < gap; i++) begin
            if (pwm_out !== 1'b0 || busy !== 1'b1 || done !== 1'b0) errs++;
            step();
        end
        for (int i = 0; i < len; i++) begin
            if (i == act_at) begin
                if (act == 1) loop_en = 1'b0;
                else if (act == 2) begin
                    wr_en = 1'b1; wr_addr = '0; wr_freq = 12'd100; wr_dur = 8'd1;
                end
            end
            if (i == act_at + 1) wr_en = 1'b0;
            e = (half != 0) && (((i / half) % 2) == 1) && ((cyc % 16) < vol);
            if (pwm_out !== e || note_idx !== ADDR_W'(idx) || busy !== 1'b1 || done !== 1'b0)
                errs++;
            step();
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL %s: %0d bad cycles, required 0", nm, errs);
        end
    endtask

    task automatic check_end(input string nm);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done pulse: got %b, required 1", nm, done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s idle after done: busy=%b done=%b, required 0 0", nm, busy, done);
        end
    endtask

    task automatic watch_idle(input int n, input string nm);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || pwm_out !== 1'b0) errs++;
            step();
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL %s: %0d non-idle cycles, required 0", nm, errs);
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b, required 0", busy); end
        checks++; if (note_idx !== '0) begin failures++; $display("FAIL reset note_idx: got %0d, required 0", note_idx); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b, required 0", done); end
        checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset pwm_out: got %b, required 0", pwm_out); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_tone();
        write_entry(0, 50, 2);
        last_idx = 0; loop_en = 1'b0; volume = 15;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL tone busy after start: got %b, required 1", busy); end
        note(0, 10, 200, 15, -1, 0, "tone half10");
        check_end("tone");
    endtask

    task automatic test_rest();
        write_entry(0, 0, 1);
        write_entry(1, 100, 1);
        last_idx = 1; loop_en = 1'b0; volume = 15;
        pulse_start();
        note(0, 0, 100, 15, -1, 0, "rest entry0");
        note(1, 5, 100, 15, -1, 0, "tone after rest");
        check_end("rest");
    endtask

    task automatic test_loop();
        last_idx = 1; loop_en = 1'b1; volume = 15;
        pulse_start();
        note(0, 0, 100, 15, -1, 0, "loop e0 pass1");
        note(1, 5, 100, 15, -1, 0, "loop e1 pass1");
        note(0, 0, 100, 15, -1, 0, "loop e0 pass2");
        note(1, 5, 100, 15, 50, 1, "loop e1 pass2");
        check_end("loop");
    endtask

    task automatic test_stop();
        write_entry(0, 50, 2);
        last_idx = 0; loop_en = 1'b0; volume = 15;
        pulse_start();
        note(0, 10, 50, 15, -1, 0, "before stop");
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop busy: got %b, required 0", busy); end
        checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL stop pwm_out: got %b, required 0", pwm_out); end
        watch_idle(300, "after stop");
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start+stop busy: got %b, required 0", busy); end
        watch_idle(50, "start+stop idle");
    endtask

    task automatic test_volume();
        write_entry(0, 50, 2);
        last_idx = 0; loop_en = 1'b0;
        volume = 0;
        pulse_start();
        note(0, 10, 200, 0, -1, 0, "volume 0");
        check_end("volume 0");
        volume = 8;
        pulse_start();
        note(0, 10, 200, 8, -1, 0, "volume 8");
        check_end("volume 8");
    endtask

    task automatic test_edge();
        write_entry(0, 600, 0);
        last_idx = 0; loop_en = 1'b0; volume = 15;
        pulse_start();
        note(0, 1, 100, 15, -1, 0, "half1 dur0");
        check_end("edge");
    endtask

    task automatic test_write_play();
        write_entry(0, 50, 1);
        last_idx = 0; loop_en = 1'b1; volume = 15;
        pulse_start();
        note(0, 10, 100, 15, 30, 2, "old note during write");
        note(0, 5, 100, 15, 50, 1, "new note next pass");
        check_end("write during play");
    endtask

    task automatic test_async_reset();
        write_entry(0, 0, 1);
        write_entry(1, 100, 1);
        last_idx = 1; loop_en = 1'b0; volume = 15;
        pulse_start();
        note(0, 0, 100, 15, -1, 0, "pre-reset e0");
        note(1, 5, 40, 15, -1, 0, "pre-reset e1");
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || note_idx !== '0 || done !== 1'b0 || pwm_out !== 1'b0) begin
            failures++;
            $display("FAIL async reset: busy=%b idx=%0d done=%b pwm=%b, required 0 0 0 0",
                     busy, note_idx, done, pwm_out);
        end
        step();
        reset = 1'b0;
        pulse_start();
        note(0, 0, 100, 15, -1, 0, "table kept e0");
        note(1, 5, 100, 15, -1, 0, "table kept e1");
        check_end("after reset");
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_idx = '0; volume = 15;
        step();
        step();
        test_reset();
        test_tone();
        test_rest();
        test_loop();
        test_stop();
        test_volume();
        test_edge();
        test_write_play();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/melody_player.md
# melody_player

Programmable square-wave melody sequencer for the clock's alarm and chime audio path. It holds a writable song table of (frequency, duration) entries and plays entries 0..last_idx in order, once or looped. Tone half-periods are computed at runtime by a sequential divider. Output is a volume-scaled PWM signal that drives the board's audio pin directly.

## Interface
Parameters:
- CLK_FREQ, 50000000, clk frequency in Hz; must fit 32 bits.
- ADDR_W, 5, song-table address width; depth = 2**ADDR_W.
- FREQ_W, 12, note frequency width in Hz; 0 = rest.
- DUR_W, 8, note duration width in ticks.
- TICK_CYCLES, 2500000, clk cycles per duration tick (50 ms at default).
- VOL_W, 4, volume width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- wr_en  in  1  song-table write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_freq  in  FREQ_W  write frequency.
- wr_dur  in  DUR_W  write duration.
- start  in  1  begin playback at entry 0.
- stop  in  1  abort playback.
- loop_en  in  1  wrap to entry 0 after last_idx.
- last_idx  in  ADDR_W  index of the final entry, latched on start.
- volume  in  VOL_W  PWM level; 0 = mute.
- busy  out  1  high from the first cycle after start until return to IDLE.
- note_idx  out  ADDR_W  entry currently loaded or playing.
- done  out  1  one-cycle pulse on normal completion.
- pwm_out  out  1  audio output.

## Operation
- Song table: DEPTH x (FREQ_W+DUR_W) with a synchronous write when wr_en=1, allowed in any state; contents are not reset.
- Entry values are latched in LOAD. A write to the playing entry takes effect only when that entry is next loaded. A same-cycle write and LOAD read of one address returns the old data.
- States:
  - IDLE: start=1 latches last_idx, clears note_idx -> LOAD.
  - LOAD (1 cycle): register freq/dur of note_idx. freq=0 -> PLAY (rest); else -> DIV.
  - DIV (exactly 32 cycles): restoring divide, half = floor((CLK_FREQ/2)/freq). half=0 is forced to 1 -> PLAY.
  - PLAY: runs for max(dur,1)*TICK_CYCLES cycles, then:
    - note_idx<last_idx -> note_idx+1, LOAD.
    - note_idx=last_idx and loop_en=1 (sampled at that end) -> note_idx=0, LOAD.
    - otherwise -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- stop=1 in any non-IDLE state -> IDLE on the next edge, with no done pulse. stop beats start in the same cycle. start while busy is ignored.
- Tone: phase is cleared on PLAY entry. A half-period counter counts 0..half-1, and phase toggles at half-1 before the counter wraps to 0.
- PWM carrier: free-running VOL_W-bit counter pc. pwm_out = phase & (pc < volume) in PLAY with freq!=0; otherwise 0.
- All arithmetic is unsigned; the divider uses 32-bit dividend, divisor and quotient.

## Timing
- Reset values: busy=0, note_idx=0, done=0, pwm_out=0, state IDLE, phase=0, all counters 0.
- start sampled high at edge N: busy=1 after N+1 (LOAD). PLAY is entered at N+34 for a tone, or at N+2 for a rest.
- Inter-note gap is 1 cycle (rest next) or 33 cycles (tone next). pwm_out=0 throughout the gap.
- done is high exactly the cycle after PLAY of the last entry ends. busy falls the following cycle.
- Tick prescaler restarts on each PLAY entry, so durations are exact and never truncated by a partial tick.
- Mid-note reset forces all outputs to their reset values immediately (asynchronous). The table is preserved.

## Test plan
- Params CLK_FREQ=1000, TICK_CYCLES=100, VOL_W=4, volume=15.
  - Write entry0=(50,2), last_idx=0, pulse start.
  - Required: half=10 (phase period 20 cycles); PLAY lasts 200 cycles; done pulses once; busy low after.
- Rest: entry0=(0,1), entry1=(100,1), last_idx=1.
  - Required: pwm_out=0 for 100 PLAY cycles; entry1 enters PLAY 33 cycles later with half=5.
- Loop: loop_en=1, last_idx=1.
  - Required: note_idx goes 0,1,0,1 with no done.
  - Clearing loop_en during entry1 -> done after entry1.
- Stop: pulse stop mid-PLAY.
  - Required: busy=0 and pwm_out=0 next cycle, no done.
  - start+stop in the same cycle from IDLE -> stays IDLE.
- Volume: volume=0 -> pwm_out stays 0.
  - volume=8 -> during phase=1, pwm_out is high 8 of every 16 cycles.
- Edge cases: freq=600 (half=0) -> half forced to 1; dur=0 -> plays 100 cycles.
  - Write entry0 during its PLAY -> new value heard on the next loop pass only.
